// File: rtl/dooz_pkg.sv
// Shared types and constants for the Dooz turn controller: state encoding,
// legal cell-code range and the eight winning line masks.
package dooz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN_A,
        ST_TURN_B,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam logic [3:0] CELL_MIN  = 4'd1;
    localparam logic [3:0] CELL_MAX  = 4'd9;
    localparam int         NUM_LINES = 8;

    // Bit k of a mask is cell k+1.
    localparam logic [NUM_LINES-1:0][8:0] WIN_LINES = {
        9'b000_000_111,   // 1 2 3
        9'b000_111_000,   // 4 5 6
        9'b111_000_000,   // 7 8 9
        9'b001_001_001,   // 1 4 7
        9'b010_010_010,   // 2 5 8
        9'b100_100_100,   // 3 6 9
        9'b100_010_001,   // 1 5 9
        9'b001_010_100    // 3 5 7
    };

    function automatic logic [8:0] cell_mask(input logic [3:0] code);
        cell_mask = '0;
        if (code >= CELL_MIN && code <= CELL_MAX)
            cell_mask = 9'd1 << (code - CELL_MIN);
    endfunction

endpackage

// File: rtl/dooz_line_check.sv
// Combinational detector: flags when an occupancy mask covers any full line.
module dooz_line_check
    import dooz_pkg::*;
(
    input  logic [8:0] mask_i,
    output logic       has_line_o
);

    always_comb begin
        has_line_o = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if ((mask_i & WIN_LINES[i]) == WIN_LINES[i])
                has_line_o = 1'b1;
        end
    end

endmodule

// File: rtl/dooz_turn_ctrl.sv
// Dooz turn sequencer: grants the board, validates moves, tracks occupancy,
// declares win/draw and forfeits stalled turns to the opponent.
module dooz_turn_ctrl
    import dooz_pkg::*;
#(
    parameter int TURN_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] p1,
    input  logic       p1_valid,
    input  logic [3:0] p2,
    input  logic       p2_valid,
    output logic       turnA,
    output logic       turnB,
    output logic [8:0] selectA,
    output logic [8:0] selectB,
    output logic       winnerA,
    output logic       winnerB,
    output logic       equal,
    output logic       move_err,
    output logic       timeout
);

    localparam int            TW      = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TURN_TIMEOUT - 1);
    localparam bit            TO_EN   = (TURN_TIMEOUT != 0);

    state_e        state_q, state_d;
    logic [8:0]    sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic          win_a_q, win_a_d, win_b_q, win_b_d;
    logic          equal_q, equal_d, err_q, err_d, to_q, to_d;
    logic          mover_b_q, mover_b_d;
    logic [3:0]    moves_q, moves_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic          line_a, line_b;
    logic          in_a, cur_valid, cur_ok;
    logic [3:0]    cur_code;
    logic [8:0]    cur_bit;

    dooz_line_check u_line_a (.mask_i(sel_a_q), .has_line_o(line_a));
    dooz_line_check u_line_b (.mask_i(sel_b_q), .has_line_o(line_b));

    // Only the board holder's keypad is looked at; the other is ignored.
    assign in_a      = (state_q == ST_TURN_A);
    assign cur_valid = in_a ? p1_valid : p2_valid;
    assign cur_code  = in_a ? p1 : p2;
    assign cur_bit   = cell_mask(cur_code);
    assign cur_ok    = (cur_bit != '0) && (((sel_a_q | sel_b_q) & cur_bit) == '0);

    always_comb begin
        state_d   = state_q;
        sel_a_d   = sel_a_q;
        sel_b_d   = sel_b_q;
        win_a_d   = win_a_q;
        win_b_d   = win_b_q;
        equal_d   = equal_q;
        mover_b_d = mover_b_q;
        moves_d   = moves_q;
        tcnt_d    = tcnt_q;
        err_d     = 1'b0;
        to_d      = 1'b0;

        if (start) begin
            state_d = ST_TURN_A;
            sel_a_d = '0;
            sel_b_d = '0;
            win_a_d = 1'b0;
            win_b_d = 1'b0;
            equal_d = 1'b0;
            moves_d = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                ST_TURN_A, ST_TURN_B: begin
                    if (cur_valid && cur_ok) begin
                        if (in_a) sel_a_d = sel_a_q | cur_bit;
                        else      sel_b_d = sel_b_q | cur_bit;
                        moves_d   = moves_q + 4'd1;
                        mover_b_d = !in_a;
                        state_d   = ST_CHECK;
                    end else begin
                        err_d = cur_valid;
                        // A rejected strobe does not restart the stall window.
                        if (TO_EN && tcnt_q == TO_LAST) begin
                            to_d    = 1'b1;
                            state_d = in_a ? ST_TURN_B : ST_TURN_A;
                            tcnt_d  = '0;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    tcnt_d = '0;
                    if (mover_b_q ? line_b : line_a) begin
                        win_a_d = win_a_q | !mover_b_q;
                        win_b_d = win_b_q | mover_b_q;
                        state_d = ST_DONE;
                    end else if (moves_q == 4'd9) begin
                        equal_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = mover_b_q ? ST_TURN_A : ST_TURN_B;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sel_a_q   <= '0;
            sel_b_q   <= '0;
            win_a_q   <= 1'b0;
            win_b_q   <= 1'b0;
            equal_q   <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            mover_b_q <= 1'b0;
            moves_q   <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            win_a_q   <= win_a_d;
            win_b_q   <= win_b_d;
            equal_q   <= equal_d;
            err_q     <= err_d;
            to_q      <= to_d;
            mover_b_q <= mover_b_d;
            moves_q   <= moves_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign turnA    = (state_q == ST_TURN_A);
    assign turnB    = (state_q == ST_TURN_B);
    assign selectA  = sel_a_q;
    assign selectB  = sel_b_q;
    assign winnerA  = win_a_q;
    assign winnerB  = win_b_q;
    assign equal    = equal_q;
    assign move_err = err_q;
    assign timeout  = to_q;

endmodule

// File: tb/tb_dooz_turn_ctrl.sv
// Self-checking bench for dooz_turn_ctrl: directed game scenarios plus a
// randomized run compared every cycle against a game-rule reference model.
module tb_dooz_turn_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset, start, p1_valid, p2_valid;
    logic [3:0] p1, p2;
    logic       turnA, turnB, winnerA, winnerB, equal, move_err, timeout;
    logic [8:0] selectA, selectB;

    int n_chk  = 0;
    int n_fail = 0;

    dooz_turn_ctrl #(.TURN_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1(p1), .p1_valid(p1_valid), .p2(p2), .p2_valid(p2_valid),
        .turnA(turnA), .turnB(turnB), .selectA(selectA), .selectB(selectB),
        .winnerA(winnerA), .winnerB(winnerB), .equal(equal),
        .move_err(move_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 A to move, 2 B to move, 3 judging, 4 over.
    int         m_phase, m_moves, m_tc, m_mover;
    logic [8:0] m_a, m_b;
    bit         m_wa, m_wb, m_eq, m_err, m_to;

    function automatic bit has_line(input logic [8:0] m);
        int ln [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                          '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        for (int i = 0; i < 8; i++)
            if (m[ln[i][0]-1] && m[ln[i][1]-1] && m[ln[i][2]-1]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_moves = 0; m_tc = 0; m_mover = 1;
        m_a = '0; m_b = '0;
        m_wa = 0; m_wb = 0; m_eq = 0; m_err = 0; m_to = 0;
    endtask

    task automatic model_step(input bit st, input bit av, input int a, input bit bv, input int b);
        bit in_a, v;
        int c;
        m_err = 0; m_to = 0;
        if (st) begin
            m_a = '0; m_b = '0; m_wa = 0; m_wb = 0; m_eq = 0;
            m_moves = 0; m_tc = 0; m_phase = 1;
        end else if (m_phase == 1 || m_phase == 2) begin
            in_a = (m_phase == 1);
            v    = in_a ? av : bv;
            c    = in_a ? a : b;
            if (v && c >= 1 && c <= 9 && !m_a[c-1] && !m_b[c-1]) begin
                if (in_a) m_a[c-1] = 1'b1; else m_b[c-1] = 1'b1;
                m_moves++;
                m_mover = m_phase;
                m_phase = 3;
            end else begin
                if (v) m_err = 1;
                if (m_tc == TO - 1) begin
                    m_to = 1; m_phase = 3 - m_phase; m_tc = 0;
                end else begin
                    m_tc++;
                end
            end
        end else if (m_phase == 3) begin
            m_tc = 0;
            if (has_line(m_mover == 1 ? m_a : m_b)) begin
                if (m_mover == 1) m_wa = 1; else m_wb = 1;
                m_phase = 4;
            end else if (m_moves == 9) begin
                m_eq = 1; m_phase = 4;
            end else begin
                m_phase = 3 - m_mover;
            end
        end
    endtask

    task automatic tick(input bit st, input bit av, input int a, input bit bv, input int b);
        start = st; p1_valid = av; p1 = 4'(a); p2_valid = bv; p2 = 4'(b);
        @(posedge clk);
        model_step(st, av, a, bv, b);
        #1;
        start = 0; p1_valid = 0; p2_valid = 0; p1 = 0; p2 = 0;
    endtask

    task automatic move(input bit pa, input int c);
        if (pa) tick(0, 1, c, 0, 0); else tick(0, 0, 0, 1, c);
        tick(0, 0, 0, 0, 0);
    endtask

    function automatic logic [24:0] outs();
        return {turnA, turnB, winnerA, winnerB, equal, move_err, timeout, selectA, selectB};
    endfunction

    task automatic test_reset();
        @(negedge clk); reset = 0; #1; model_reset();
        n_chk++;
        if (outs() !== 25'd0) begin n_fail++; $display("FAIL reset_outputs actual=%h required=0", outs()); end
        @(negedge clk); reset = 1;
        tick(1, 0, 0, 0, 0);
        n_chk++;
        if ({turnA, turnB, selectA, selectB} !== {2'b10, 18'd0}) begin
            n_fail++; $display("FAIL start_turnA actual=%b required=%b", {turnA, turnB, selectA, selectB}, {2'b10, 18'd0});
        end
    endtask

    task automatic test_win();
        tick(1, 0, 0, 0, 0);
        move(1, 1); move(0, 5); move(1, 2); move(0, 9);
        tick(0, 1, 3, 0, 0);
        n_chk++;
        if ({turnA, selectA} !== {1'b0, 9'b000000111}) begin
            n_fail++; $display("FAIL win_check_cycle actual=%b required=%b", {turnA, selectA}, {1'b0, 9'b000000111});
        end
        tick(0, 0, 0, 0, 0);
        n_chk++;
        if ({winnerA, winnerB, equal, turnA, turnB} !== 5'b10000) begin
            n_fail++; $display("FAIL win_flags actual=%b required=10000", {winnerA, winnerB, equal, turnA, turnB});
        end
        n_chk++;
        if ({selectA, selectB} !== {9'b000000111, 9'b100010000}) begin
            n_fail++; $display("FAIL win_masks actual=%b_%b required=000000111_100010000", selectA, selectB);
        end
        tick(0, 1, 4, 1, 6);
        tick(0, 0, 0, 0, 0);
        n_chk++;
        if ({selectA, selectB, winnerA, move_err} !== {9'b000000111, 9'b100010000, 2'b10}) begin
            n_fail++; $display("FAIL done_hold actual=%b_%b_%b%b", selectA, selectB, winnerA, move_err);
        end
    endtask

    task automatic test_done_restart();
        tick(1, 0, 0, 0, 0);
        n_chk++;
        if ({turnA, winnerA, winnerB, equal, selectA, selectB} !== {4'b1000, 18'd0}) begin
            n_fail++; $display("FAIL done_restart actual=%b", {turnA, winnerA, winnerB, equal, selectA, selectB});
        end
    endtask

    task automatic test_draw();
        int seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) move(i % 2 == 0, seq[i]);
        n_chk++;
        if ({equal, winnerA, winnerB} !== 3'b100) begin
            n_fail++; $display("FAIL draw_flags actual=%b required=100", {equal, winnerA, winnerB});
        end
        n_chk++;
        if ({selectA, selectB} !== {9'b110001101, 9'b001110010}) begin
            n_fail++; $display("FAIL draw_masks actual=%b_%b required=110001101_001110010", selectA, selectB);
        end
    endtask

    task automatic test_bad_moves();
        int codes [3] = '{5, 0, 12};
        tick(1, 0, 0, 0, 0);
        move(1, 5);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, codes[i]);
            n_chk++;
            if ({move_err, turnB, selectA, selectB} !== {2'b11, 9'b000010000, 9'd0}) begin
                n_fail++; $display("FAIL bad_move_%0d actual=%b required=%b", codes[i],
                                   {move_err, turnB, selectA, selectB}, {2'b11, 9'b000010000, 9'd0});
            end
        end
        tick(0, 0, 0, 0, 0);
        n_chk++;
        if (move_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width actual=%b required=0", move_err); end
    endtask

    task automatic test_simultaneous();
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 4, 1, 6);
        n_chk++;
        if ({turnA, selectA, selectB} !== {1'b0, 9'b000001000, 9'd0}) begin
            n_fail++; $display("FAIL simultaneous actual=%b_%b_%b required=0_000001000_000000000", turnA, selectA, selectB);
        end
    endtask

    task automatic test_timeout();
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) tick(0, 0, 0, 0, 0);
        n_chk++;
        if ({timeout, turnA} !== 2'b01) begin n_fail++; $display("FAIL timeout_early actual=%b required=01", {timeout, turnA}); end
        tick(0, 0, 0, 0, 0);
        n_chk++;
        if ({timeout, turnA, turnB, selectA, selectB} !== {3'b101, 18'd0}) begin
            n_fail++; $display("FAIL timeout_fire actual=%b", {timeout, turnA, turnB, selectA, selectB});
        end
        tick(0, 0, 0, 0, 0);
        n_chk++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse actual=%b required=0", timeout); end
    endtask

    task automatic test_midgame_reset();
        tick(1, 0, 0, 0, 0);
        move(1, 1);
        @(posedge clk); #2; reset = 0; #1; model_reset();
        n_chk++;
        if (outs() !== 25'd0) begin n_fail++; $display("FAIL midgame_reset actual=%h required=0", outs()); end
        @(negedge clk); reset = 1;
        tick(1, 0, 0, 0, 0);
        n_chk++;
        if ({turnA, selectA, selectB} !== {1'b1, 18'd0}) begin
            n_fail++; $display("FAIL restart_after_reset actual=%b", {turnA, selectA, selectB});
        end
    endtask

    task automatic test_random();
        logic [24:0] exp;
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit st, av, bv;
            int a, b;
            st = ($urandom_range(0, 49) == 0);
            av = ($urandom_range(0, 1) == 1);
            bv = ($urandom_range(0, 1) == 1);
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
            b  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
            tick(st, av, a, bv, b);
            exp = {m_phase == 1, m_phase == 2, m_wa, m_wb, m_eq, m_err, m_to, m_a, m_b};
            n_chk++;
            if (outs() !== exp) begin
                n_fail++; $display("FAIL random_cycle_%0d actual=%b required=%b", i, outs(), exp);
            end
        end
    endtask

    initial begin
        reset = 0; start = 0; p1_valid = 0; p2_valid = 0; p1 = 0; p2 = 0;
        model_reset();
        test_reset();
        test_win();
        test_done_restart();
        test_draw();
        test_bad_moves();
        test_simultaneous();
        test_timeout();
        test_midgame_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
